// File: rtl/w5300_parallel_if_rw.sv
// Free-running W5300 parallel bus master: one read or write access per
// STROBE_CYCLES + 3 clocks, operation and operands sampled when leaving IDLE.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | held in reset, bus inactive, rw_ready low
// ST_IDLE   | one cycle, rw_ready high, inputs sampled on exit
// ST_SETUP  | cs_n low, address and direction valid, write data driven
// ST_STROBE | rd_n or we_n low for STROBE_CYCLES cycles
// ST_HOLD   | cs_n low, strobes released, address/data held
module w5300_parallel_if_rw #(
  parameter int STROBE_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [15:0] data,
  output logic [9:0]  addr,
  output logic        cs_n,
  output logic        rd_n,
  output logic        we_n,
  output logic        rw_n,
  input  logic [10:0] c_addr,
  input  logic [15:0] c_idata,
  output logic [15:0] c_odata,
  output logic        rw_ready
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           wr_q;
  logic [15:0]    wdata_q;
  logic           drive_q;
  logic           op_wr;
  logic           cs_n_nxt, rd_n_nxt, we_n_nxt, rw_n_nxt, ready_nxt, drive_nxt;

  // The operation for the coming access is the live input only on the IDLE exit edge.
  assign op_wr = (state == ST_IDLE) ? c_addr[10] : wr_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RESET:  state_nxt = ST_IDLE;
      ST_IDLE:   state_nxt = ST_SETUP;
      ST_SETUP: begin
        state_nxt = ST_STROBE;
        cnt_nxt   = CW'(STROBE_CYCLES - 1);
      end
      ST_STROBE: begin
        if (cnt == '0) state_nxt = ST_HOLD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_HOLD:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_RESET;
    endcase
  end

  // Bus outputs are computed for the state being entered and registered.
  always_comb begin
    cs_n_nxt  = 1'b1;
    rd_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    rw_n_nxt  = 1'b1;
    ready_nxt = 1'b0;
    drive_nxt = 1'b0;
    case (state_nxt)
      ST_IDLE:  ready_nxt = 1'b1;
      ST_SETUP, ST_HOLD: begin
        cs_n_nxt  = 1'b0;
        rw_n_nxt  = ~op_wr;
        drive_nxt = op_wr;
      end
      ST_STROBE: begin
        cs_n_nxt  = 1'b0;
        rw_n_nxt  = ~op_wr;
        drive_nxt = op_wr;
        rd_n_nxt  = op_wr;
        we_n_nxt  = ~op_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      cnt      <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      addr     <= '0;
      drive_q  <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      we_n     <= 1'b1;
      rw_n     <= 1'b1;
      rw_ready <= 1'b0;
      c_odata  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      drive_q  <= drive_nxt;
      cs_n     <= cs_n_nxt;
      rd_n     <= rd_n_nxt;
      we_n     <= we_n_nxt;
      rw_n     <= rw_n_nxt;
      rw_ready <= ready_nxt;
      if (state == ST_IDLE) begin
        wr_q    <= c_addr[10];
        addr    <= c_addr[9:0];
        wdata_q <= c_idata;
      end
      if (state == ST_STROBE && state_nxt == ST_HOLD && !wr_q)
        c_odata <= data;
    end
  end

  assign data = drive_q ? wdata_q : 16'bz;

endmodule

// File: tb/tb_w5300_parallel_if_rw.sv
// Directed bench for w5300_parallel_if_rw: cycle-by-cycle bus checks of
// reads, writes, back-to-back alternation, mid-access input changes and reset.
module tb_w5300_parallel_if_rw;

  localparam int NSTB = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  tri1  [15:0] data_bus;
  logic [9:0]  addr;
  logic        cs_n, rd_n, we_n, rw_n;
  logic [10:0] c_addr = '0;
  logic [15:0] c_idata = '0;
  logic [15:0] c_odata;
  logic        rw_ready;

  logic        tb_drv = 1'b0;
  logic [15:0] tb_data = '0;
  logic [15:0] od_model = '0;
  int          chk_cnt = 0;
  int          err_cnt = 0;

  assign data_bus = tb_drv ? tb_data : 16'bz;

  always #5 clk = ~clk;

  w5300_parallel_if_rw #(.STROBE_CYCLES(NSTB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data_bus),
    .addr     (addr),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .we_n     (we_n),
    .rw_n     (rw_n),
    .c_addr   (c_addr),
    .c_idata  (c_idata),
    .c_odata  (c_odata),
    .rw_ready (rw_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE with c_addr/c_idata already set; ends at the next IDLE negedge.
  task automatic do_access(input logic wr, input logic [9:0] a, input logic [15:0] wd,
                           input logic [15:0] rdv);
    logic [15:0] bus_exp;
    bus_exp = wr ? wd : 16'hFFFF;
    @(negedge clk);
    chk("setup_ready", rw_ready, 0);
    chk("setup_cs_n", cs_n, 0);
    chk("setup_rw_n", rw_n, !wr);
    chk("setup_rd_n", rd_n, 1);
    chk("setup_we_n", we_n, 1);
    chk("setup_addr", addr, a);
    chk("setup_bus", data_bus, bus_exp);
    chk("setup_odata", c_odata, od_model);
    if (!wr) begin
      tb_data = rdv;
      tb_drv  = 1'b1;
    end
    for (int i = 0; i < NSTB; i++) begin
      @(negedge clk);
      chk("stb_ready", rw_ready, 0);
      chk("stb_cs_n", cs_n, 0);
      chk("stb_rd_n", rd_n, wr);
      chk("stb_we_n", we_n, !wr);
      chk("stb_rw_n", rw_n, !wr);
      chk("stb_addr", addr, a);
      chk("stb_bus", data_bus, wr ? wd : rdv);
      chk("stb_odata", c_odata, od_model);
      if (i == 1) begin
        c_addr  = {~wr, ~a};
        c_idata = ~wd;
      end
    end
    @(negedge clk);
    tb_drv = 1'b0;
    #1;
    if (!wr) od_model = rdv;
    chk("hold_ready", rw_ready, 0);
    chk("hold_cs_n", cs_n, 0);
    chk("hold_rd_n", rd_n, 1);
    chk("hold_we_n", we_n, 1);
    chk("hold_rw_n", rw_n, !wr);
    chk("hold_addr", addr, a);
    chk("hold_bus", data_bus, bus_exp);
    chk("hold_odata", c_odata, od_model);
    @(negedge clk);
    chk("idle_ready", rw_ready, 1);
    chk("idle_cs_n", cs_n, 1);
    chk("idle_rd_n", rd_n, 1);
    chk("idle_we_n", we_n, 1);
    chk("idle_rw_n", rw_n, 1);
    chk("idle_addr", addr, a);
    chk("idle_bus", data_bus, 16'hFFFF);
    chk("idle_odata", c_odata, od_model);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, rw_ready, 0);
    chk({tag, "_cs_n"}, cs_n, 1);
    chk({tag, "_rd_n"}, rd_n, 1);
    chk({tag, "_we_n"}, we_n, 1);
    chk({tag, "_rw_n"}, rw_n, 1);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_odata"}, c_odata, 0);
    chk({tag, "_bus"}, data_bus, 16'hFFFF);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] cur_a;
    logic [15:0] cur_d;

    c_addr  = 11'h402;
    c_idata = 16'h0001;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", rw_ready, 1);
    chk("rel_cs_n", cs_n, 1);

    do_access(1'b1, 10'h002, 16'h0001, 16'h0000);

    c_addr  = 11'h004;
    c_idata = 16'h0001;
    do_access(1'b0, 10'h004, 16'h0001, 16'hA5A5);
    chk("read_result", c_odata, 16'hA5A5);

    cur_a = 11'h004;
    cur_d = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      cur_a   = {~cur_a[10], cur_a[9:0] + 10'd2};
      cur_d   = cur_d + 16'd1;
      c_addr  = cur_a;
      c_idata = cur_d;
      do_access(cur_a[10], cur_a[9:0], cur_d, 16'h1000 + 16'(k));
    end
    chk("alt_odata", c_odata, 16'h1003);

    c_addr  = 11'h410;
    c_idata = 16'hBEEF;
    @(negedge clk);
    chk("abort_setup_bus", data_bus, 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("abort_pre_we_n", we_n, 0);
    rst_n = 1'b0;
    #1;
    od_model = '0;
    chk_reset_outputs("abort");
    @(negedge clk);
    chk("abort_held_ready", rw_ready, 0);
    chk("abort_held_we_n", we_n, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerel_ready", rw_ready, 1);

    c_addr  = 11'h020;
    c_idata = 16'h0000;
    do_access(1'b0, 10'h020, 16'h0000, 16'h5A5A);
    chk("final_odata", c_odata, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/w5300_parallel_if_rw.md
W5300_PARALLEL_IF_RW -- requirements
Module: w5300_parallel_if_rw

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 6: number of clock cycles rd_n/we_n is held low (minimum 1).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data  inout  16  W5300 data bus; driven only during write cycles, high-Z otherwise.
REQ-006 addr  output  10  W5300 address bus.
REQ-007 cs_n  output  1  W5300 chip select, active low.
REQ-008 rd_n  output  1  W5300 read strobe, active low.
REQ-009 we_n  output  1  W5300 write strobe, active low.
REQ-010 rw_n  output  1  bus direction flag: 1 = read, 0 = write (for external transceiver).
REQ-011 c_addr  input  11  [9:0] target address; [10] operation: 1 = write, 0 = read.
REQ-012 c_idata  input  16  write data.
REQ-013 c_odata  output  16  last read data, registered.
REQ-014 rw_ready  output  1  1 = idle (previous access complete), 0 = access ongoing.

Function
REQ-015 SHALL be a free-running FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE, no start input.
REQ-016 IDLE SHALL last exactly 1 cycle; rw_ready = 1 only in IDLE.
REQ-017 On the edge leaving IDLE, c_addr and c_idata SHALL be latched; later input changes do not affect the running access.
REQ-018 SETUP: 1 cycle; cs_n = 0, addr = latched address, rw_n = NOT latched c_addr[10]; strobes high.
REQ-019 STROBE: STROBE_CYCLES cycles; cs_n = 0; rd_n = 0 for read, we_n = 0 for write; never both low.
REQ-020 HOLD: 1 cycle; cs_n = 0, strobes high, addr/rw_n/data unchanged.
REQ-021 Access period SHALL be STROBE_CYCLES + 3 cycles (9 at default), ready-high to ready-high.
REQ-022 Write: data SHALL be driven with latched c_idata from SETUP through HOLD inclusive; high-Z in IDLE.
REQ-023 Read: data SHALL stay high-Z throughout; c_odata SHALL capture data on the edge ending the last STROBE cycle and hold until the next read.
REQ-024 Write accesses SHALL NOT modify c_odata.
REQ-025 In IDLE: cs_n = rd_n = we_n = rw_n = 1; addr holds last value.
REQ-026 All bus outputs SHALL be registered (glitch-free).

Reset
REQ-027 On rst_n = 0 (asynchronous, also mid-access): FSM -> RESET state; cs_n = rd_n = we_n = rw_n = 1, addr = 0, c_odata = 0, rw_ready = 0, data high-Z.
REQ-028 First rising clk after rst_n deasserts SHALL enter IDLE (rw_ready rises); accesses then proceed per REQ-015.
REQ-029 Reset asserted mid-access SHALL abort it immediately; no partial write strobe may remain low.

Verification
REQ-030 Reset release -> rw_ready 0 then 1 after one edge; all control outputs 1, data high-Z, c_odata 0.
REQ-031 c_addr = 11'h402, c_idata = 16'h0001 -> rw_n = 0, addr = 10'h002, we_n low 6 cycles, data = 16'h0001 SETUP..HOLD, rd_n stays 1.
REQ-032 c_addr = 11'h004, data bus driven 16'hA5A5 by bench -> rd_n low 6 cycles, rw_n = 1, DUT data high-Z, c_odata = 16'hA5A5 after access.
REQ-033 Bench increments address by 2, toggles c_addr[10] and increments c_idata on each rw_ready rise -> alternating write/read, period 9 cycles, each access uses values sampled at the IDLE edge.
REQ-034 Change c_addr/c_idata mid-STROBE -> addr and data bus unchanged until next access.
REQ-035 Assert rst_n low during STROBE of a write -> we_n, cs_n rise immediately, data high-Z, rw_ready 0.
